muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port Funct3, input, 3, operation select:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-006 The block SHALL have port SrcA, input, DATA_WIDTH, the multiplicand or dividend.
REQ-007 The block SHALL have port SrcB, input, DATA_WIDTH, the multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1, high while a computation is in progress; the pipeline stalls EX on it.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking Result valid.
REQ-010 The block SHALL have port Result, output, DATA_WIDTH, a registered result.

Function
REQ-011 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL latch Funct3, SrcA and SrcB, clear the iteration counter and enter CALC.
REQ-013 CALC SHALL perform exactly DATA_WIDTH radix-2 iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-014 On the edge that completes the last iteration, the block SHALL write Result and enter DONE.
REQ-015 DONE SHALL last one cycle, then go to IDLE unless start=1 (see REQ-012).
REQ-016 Latency SHALL be fixed: with start sampled at edge T0, busy=1 from T0 to T32, then done=1 and Result valid for the cycle after T32 (DATA_WIDTH=32).
REQ-017 Latency SHALL be identical for every Funct3 and every operand value, including the special cases below.
REQ-018 busy SHALL equal (state==CALC); done SHALL equal (state==DONE).
REQ-019 start while in CALC SHALL be ignored; the operands in flight SHALL NOT change.
REQ-020 Result SHALL hold its value until the next write; only a completed operation or reset changes it.
REQ-021 Multiply arithmetic:
- the product is 2*DATA_WIDTH bits wide
- MUL returns the low half
- MULH treats both operands as signed and returns the high half
- MULHSU treats SrcA as signed and SrcB as unsigned and returns the high half
- MULHU treats both as unsigned and returns the high half
REQ-022 Signed multiply and divide SHALL operate on magnitudes and apply sign correction at completion.
- DIV/REM: the quotient truncates toward zero
- DIV/REM: the remainder takes the sign of the dividend
REQ-023 Divide by zero: DIV/DIVU SHALL return all ones, and REM/REMU SHALL return SrcA.
REQ-024 Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-025 Intermediate values SHALL wrap modulo their register width, with no saturation.
REQ-026 An undefined state SHALL recover to IDLE on the next edge.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, Result=0, and clear the counter and all operand and accumulator registers.
REQ-028 Reset in CALC or DONE SHALL abort the operation; done SHALL NOT pulse for it.
REQ-029 Reset SHALL take priority over start on the same edge.
REQ-030 The first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-031 The bench SHALL check MUL, SrcA=7, SrcB=0xFFFFFFFD:
- busy is high for 32 cycles
- done pulses once, 33 edges after start
- Result=0xFFFFFFEB
REQ-032 The bench SHALL check the high-half multiplies:
- MULH 0x80000000*0x80000000 -> 0x40000000
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
- MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
REQ-033 The bench SHALL check signed divide, SrcA=0xFFFFFFF9, SrcB=2:
- DIV -> 0xFFFFFFFD
- REM -> 0xFFFFFFFF
- DIVU -> 0x7FFFFFFC
- REMU -> 1
REQ-034 The bench SHALL check the special divides, each with the normal 33-cycle latency:
- DIVU 5/0 -> 0xFFFFFFFF
- REMU 5/0 -> 5
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000
- REM of the same operands -> 0
REQ-035 The bench SHALL check start during CALC: MUL 3*4, then start=1 at cycle 10 with other operands -> Result=12, and no second done.
REQ-036 The bench SHALL check start during DONE: a back-to-back start accepts a new op, and done pulses again 33 edges later.
REQ-037 The bench SHALL check reset mid-operation: rst_n=0 at cycle 15 -> busy=0, done=0, Result=0, and no done pulse follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add / restoring divide on magnitudes, fixed latency.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  mc;
  logic          neg;
  logic          bzero;

  logic          a_sgn;
  logic          b_sgn;
  logic          sa;
  logic          sb;
  logic          nsgn;
  logic [W-1:0]  ma;
  logic [W-1:0]  mb;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (Funct3)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    sa   = a_sgn & SrcA[W-1];
    sb   = b_sgn & SrcB[W-1];
    ma   = sa ? -SrcA : SrcA;
    mb   = sb ? -SrcB : SrcB;
    // remainder follows the dividend, everything else the xor
    nsgn = (Funct3[2] & Funct3[1]) ? sa : (sa ^ sb);
  end

  logic [W:0]     sum;
  logic [W:0]     sh;
  logic [W:0]     diff;
  logic [W-1:0]   nhi;
  logic [W-1:0]   nlo;
  logic [2*W-1:0] prod;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic [W-1:0]   res;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    sh   = {hi, lo[W-1]};
    diff = sh - {1'b0, mc};
    if (!op[2]) begin
      {nhi, nlo} = {sum, lo[W-1:1]};
    end else if (!diff[W]) begin
      nhi = diff[W-1:0];
      nlo = {lo[W-2:0], 1'b1};
    end else begin
      nhi = sh[W-1:0];
      nlo = {lo[W-2:0], 1'b0};
    end
    prod = neg ? -{nhi, nlo} : {nhi, nlo};
    q    = neg ? -nlo : nlo;
    r    = neg ? -nhi : nhi;
    unique case (op)
      3'b000:                 res = prod[W-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*W-1:W];
      3'b100, 3'b101:         res = bzero ? '1 : q;
      default:                res = r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      hi     <= '0;
      lo     <= '0;
      mc     <= '0;
      neg    <= 1'b0;
      bzero  <= 1'b0;
      Result <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            op    <= Funct3;
            hi    <= '0;
            lo    <= ma;
            mc    <= mb;
            neg   <= nsgn;
            bzero <= (SrcB == '0);
            cnt   <= '0;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          hi  <= nhi;
          lo  <= nlo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            Result <= res;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit.
// Expected results queued at issue, popped on done.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Funct3(Funct3),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .busy  (busy),
    .done  (done),
    .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] held = '0;

  localparam int N = 11;
  logic [2:0]  tf [N] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                          3'b101, 3'b111, 3'b101, 3'b111, 3'b100,
                          3'b110};
  logic [31:0] ta [N] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                          32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                          32'hFFFFFFF9, 32'd5, 32'd5,
                          32'h80000000, 32'h80000000};
  logic [31:0] tb [N] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                          32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                          32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] te [N] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                          32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC,
                          32'd1, 32'hFFFFFFFF, 32'd5,
                          32'h80000000, 32'd0};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge; start is sampled by the next posedge (T0)
  task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e);
    start  = 1'b1;
    Funct3 = f;
    SrcA   = a;
    SrcB   = b;
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
  endtask

  // sample n = cycles after T0; busy for n=1..32, done at n=33
  task automatic finish_op(input int poke);
    logic [31:0] exp;
    for (int n = 1; n <= 33; n++) begin
      if (poke > 0 && n == poke + 1) start = 1'b0;
      if (n <= 32) begin
        check($sformatf("busy_n%0d", n), 32'({busy, done}), 32'h2);
      end else begin
        check("done_pulse", 32'({busy, done}), 32'h1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        check("result", Result, exp);
        held = exp;
      end
      if (poke > 0 && n == poke) begin
        start  = 1'b1;
        Funct3 = 3'b101;
        SrcA   = 32'd100;
        SrcB   = 32'd7;
      end
      if (n < 33) @(negedge clk);
    end
  endtask

  task automatic quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle", 32'({busy, done}), 32'h0);
      check("hold", Result, held);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    Funct3 = '0;
    SrcA   = '0;
    SrcB   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy_done", 32'({busy, done}), 32'h0);
    check("rst_result", Result, 32'h0);

    rst_n = 1'b1;
    start_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    finish_op(0);
    quiet(2);

    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      start_op(tf[i], ta[i], tb[i], te[i]);
      finish_op(0);
      quiet(1);
    end

    @(negedge clk);
    start_op(3'b000, 32'd3, 32'd4, 32'd12);
    finish_op(10);
    quiet(40);

    @(negedge clk);
    start_op(3'b000, 32'd123, 32'd456, 32'h0000DB18);
    finish_op(0);
    start_op(3'b101, 32'd1000, 32'd7, 32'd142);
    finish_op(0);
    quiet(2);

    @(negedge clk);
    start_op(3'b000, 32'd9, 32'd9, 32'd81);
    for (int n = 1; n < 15; n++) @(negedge clk);
    rst_n  = 1'b0;
    start  = 1'b1;
    Funct3 = 3'b000;
    SrcA   = 32'd2;
    SrcB   = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("midrst_busy_done", 32'({busy, done}), 32'h0);
    check("midrst_result", Result, 32'h0);
    void'(sb_q.pop_back());
    held  = '0;
    rst_n = 1'b1;
    quiet(40);

    @(negedge clk);
    start_op(3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);
    finish_op(0);
    quiet(2);
    check("queue_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
